// File: rtl/stall_countdown_if.sv
// Purpose: hazard-unit <-> stall countdown bundle (load request in, per-pipe stalls and status out).
// Latency: none; plain wiring.
// Backpressure: none; the hazard unit owns the request side, the countdown owns the status side.
interface stall_countdown_if #(
    parameter int CNT_W = 3
);
    logic             CDen;
    logic [CNT_W-1:0] CDAmt;
    logic             CDsel;
    logic             freeze;
    logic             flush;
    logic             stall_1;
    logic             stall_2;
    logic [CNT_W-1:0] cd_count;
    logic             cd_busy;
    logic             cd_done;
    logic             cd_err;

    // Hazard-unit side: issues load requests and pipeline control, observes stalls.
    modport master (
        output CDen, CDAmt, CDsel, freeze, flush,
        input  stall_1, stall_2, cd_count, cd_busy, cd_done, cd_err
    );

    // Countdown side: consumes requests and drives the registered stall outputs.
    modport slave (
        input  CDen, CDAmt, CDsel, freeze, flush,
        output stall_1, stall_2, cd_count, cd_busy, cd_done, cd_err
    );
endinterface

// File: rtl/stall_countdown.sv
// Purpose: latch a stall length and target pipe, then hold that pipe's stall for exactly that many cycles.
// Latency: load sampled at edge t stalls cycles t+1..t+N; cd_done pulses in cycle t+N+1.
// Backpressure: loads during an active countdown are dropped and flagged in sticky cd_err; freeze holds the count.
module stall_countdown #(
    parameter int CNT_W   = 3,
    parameter int MAX_AMT = 7
) (
    input  logic              clk,
    input  logic              rst,
    stall_countdown_if.slave  cd
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    // Compare in one extra bit so the clamp stays meaningful for any MAX_AMT.
    localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_AMT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sel_q, sel_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] load_amt;
    logic             load_ok;

    // Clamp the requested length and qualify a load (zero length and flush both suppress it).
    always_comb begin
        load_amt = cd.CDAmt;
        if ({1'b0, cd.CDAmt} > MAX_EXT) begin
            load_amt = MAX_EXT[CNT_W-1:0];
        end
        load_ok = cd.CDen && (cd.CDAmt != '0) && !cd.flush;
    end

    // State register; reset drops everything immediately, even mid-countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    // Next-state: flush wins over everything, then load / countdown / freeze.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sel_d   = sel_q;
        err_d   = err_q;
        if (cd.flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (load_ok) begin
                        state_d = COUNT;
                        count_d = load_amt;
                        sel_d   = cd.CDsel;
                    end else begin
                        state_d = IDLE;
                    end
                end
                COUNT: begin
                    // A request while busy is never honoured, frozen or not.
                    if (cd.CDen) begin
                        err_d = 1'b1;
                    end
                    if (count_q == '0) begin
                        state_d = DONE;
                    end else if (!cd.freeze) begin
                        count_d = count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Outputs decode from registers only, so no input reaches an output combinationally.
    assign cd.cd_busy  = (state_q == COUNT);
    assign cd.stall_1  = (state_q == COUNT) && !sel_q;
    assign cd.stall_2  = (state_q == COUNT) &&  sel_q;
    assign cd.cd_done  = (state_q == DONE);
    assign cd.cd_count = count_q;
    assign cd.cd_err   = err_q;
endmodule

// File: tb/tb_stall_countdown.sv
module tb_stall_countdown;
    logic clk;
    logic rst;

    stall_countdown_if #(.CNT_W(3)) cd_if ();

    stall_countdown #(.CNT_W(3), .MAX_AMT(7)) dut (
        .clk (clk),
        .rst (rst),
        .cd  (cd_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vec;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    // Packed view: {stall_1, stall_2, cd_count[2:0], cd_busy, cd_done, cd_err}
    function automatic logic [7:0] e(input logic s1, input logic s2, input logic [2:0] cnt,
                                     input logic b, input logic d, input logic er);
        return {s1, s2, cnt, b, d, er};
    endfunction

    // Monitor: every observation point away from the clock edge, pop and compare.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       x;
            logic [7:0] act;
            x   = exp_q.pop_front();
            act = {cd_if.stall_1, cd_if.stall_2, cd_if.cd_count,
                   cd_if.cd_busy, cd_if.cd_done, cd_if.cd_err};
            n_cmp++;
            if (act !== x.vec) begin
                n_bad++;
                $display("FAIL %s: got s1s2_cnt_bde=%b required=%b", x.name, act, x.vec);
            end
        end
    end

    task automatic drive(input logic en, input logic [2:0] amt, input logic sel,
                         input logic frz, input logic fl);
        cd_if.CDen   = en;
        cd_if.CDAmt  = amt;
        cd_if.CDsel  = sel;
        cd_if.freeze = frz;
        cd_if.flush  = fl;
    endtask

    // One cycle: inputs sampled at the next edge, expectation is the state after it.
    task automatic step(input logic en, input logic [2:0] amt, input logic sel,
                        input logic frz, input logic fl, input logic [7:0] ev, input string nm);
        exp_t x;
        drive(en, amt, sel, frz, fl);
        @(posedge clk);
        x.vec  = ev;
        x.name = nm;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // Let one edge pass with idle inputs, then hit reset asynchronously well before the next edge.
    task automatic async_reset(input string nm);
        exp_t x;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        x.vec  = e(0, 0, 3'd0, 0, 0, 0);
        x.name = nm;
        exp_q.push_back(x);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_t x;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        x.vec = e(0, 0, 3'd0, 0, 0, 0); x.name = "reset_state";
        exp_q.push_back(x);
        @(negedge clk);
        rst = 1'b0;

        // Pipe-2 countdown of 3
        step(1, 3'd3, 1, 0, 0, e(0, 1, 3'd3, 1, 0, 0), "t1_cnt3");
        step(0, 0,    0, 0, 0, e(0, 1, 3'd2, 1, 0, 0), "t1_cnt2");
        step(0, 0,    0, 0, 0, e(0, 1, 3'd1, 1, 0, 0), "t1_cnt1");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 0), "t1_done");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t1_idle");

        // Pipe-1 countdown of 2 with two frozen cycles
        step(1, 3'd2, 0, 0, 0, e(1, 0, 3'd2, 1, 0, 0), "t2_cnt2");
        step(0, 0,    0, 0, 0, e(1, 0, 3'd1, 1, 0, 0), "t2_cnt1");
        step(0, 0,    0, 1, 0, e(1, 0, 3'd1, 1, 0, 0), "t2_frz1");
        step(0, 0,    0, 1, 0, e(1, 0, 3'd1, 1, 0, 0), "t2_frz2");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 0), "t2_done");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t2_idle");

        // Retrigger attempt during countdown of 5: ignored, sticky error
        step(1, 3'd5, 1, 0, 0, e(0, 1, 3'd5, 1, 0, 0), "t3_cnt5");
        step(0, 0,    0, 0, 0, e(0, 1, 3'd4, 1, 0, 0), "t3_cnt4");
        step(1, 3'd1, 0, 0, 0, e(0, 1, 3'd3, 1, 0, 1), "t3_err_cnt3");
        step(0, 0,    0, 0, 0, e(0, 1, 3'd2, 1, 0, 1), "t3_cnt2");
        step(0, 0,    0, 0, 0, e(0, 1, 3'd1, 1, 0, 1), "t3_cnt1");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 1), "t3_done");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 1), "t3_err_sticky");
        async_reset("t3_rst_clears_err");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t3_idle_after_rst");

        // Flush on 2nd stall cycle, with a simultaneous CDen and freeze
        step(1, 3'd4, 0, 0, 0, e(1, 0, 3'd4, 1, 0, 0), "t4_cnt4");
        step(0, 0,    0, 0, 0, e(1, 0, 3'd3, 1, 0, 0), "t4_cnt3");
        step(1, 3'd2, 1, 1, 1, e(0, 0, 3'd0, 0, 0, 0), "t4_flush");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t4_no_done");

        // Back-to-back load in the DONE cycle, switching pipes
        step(1, 3'd2, 1, 0, 0, e(0, 1, 3'd2, 1, 0, 0), "t5_cnt2");
        step(0, 0,    0, 0, 0, e(0, 1, 3'd1, 1, 0, 0), "t5_cnt1");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 0), "t5_done");
        step(1, 3'd1, 0, 0, 0, e(1, 0, 3'd1, 1, 0, 0), "t5_b2b_cnt1");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 0), "t5_done2");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t5_idle");

        // Load accepted while freeze is high in IDLE
        step(1, 3'd1, 1, 1, 0, e(0, 1, 3'd1, 1, 0, 0), "t6_frz_load");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 0), "t6_done");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t6_idle");

        // Zero-length request is ignored without error
        step(1, 3'd0, 1, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t7_amt0");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t7_idle");

        // Async reset mid-countdown (count would be 2)
        step(1, 3'd3, 0, 0, 0, e(1, 0, 3'd3, 1, 0, 0), "t8_cnt3");
        async_reset("t8_async_rst");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 0), "t8_idle");

        // Flush beats freeze
        step(1, 3'd2, 1, 0, 0, e(0, 1, 3'd2, 1, 0, 0), "t9_cnt2");
        step(0, 0,    0, 1, 1, e(0, 0, 3'd0, 0, 0, 0), "t9_flush_frz");

        // CDen while frozen in COUNT still flags error
        step(1, 3'd1, 0, 0, 0, e(1, 0, 3'd1, 1, 0, 0), "t10_cnt1");
        step(1, 3'd3, 0, 1, 0, e(1, 0, 3'd1, 1, 0, 1), "t10_frz_err");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 1, 1), "t10_done");
        step(0, 0,    0, 0, 0, e(0, 0, 3'd0, 0, 0, 1), "t10_idle");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stall_countdown.md
Name: stall_countdown

Overview:
- Countdown register on the consuming side of the hazard-unit stall request (CDen/CDAmt).
- Latches a requested stall length and target pipe, then drives the registered per-pipe stall signals (stall_1, stall_2) for exactly that many cycles.
- Those stall signals feed back into the hazard unit and the pipeline enables of the dual-issue core.
- Supports freeze (hold count while MEM is halted for a syscall), flush (branch/exception squash), and reports completion and protocol errors.

Parameters:
CNT_W, 3, width of the stall amount and internal counter.
MAX_AMT, 7, largest accepted stall length; larger requests clamp to MAX_AMT (must be ≤ 2^CNT_W−1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
CDen  input  1  load request from hazard unit, sampled on clk
CDAmt  input  CNT_W  requested stall cycles
CDsel  input  1  target pipe: 0 = pipe 1, 1 = pipe 2
freeze  input  1  hold counter (MEM halted); stall outputs keep their value
flush  input  1  abort any countdown
stall_1  output  1  stall pipe 1
stall_2  output  1  stall pipe 2
cd_count  output  CNT_W  remaining stall cycles
cd_busy  output  1  countdown active
cd_done  output  1  one-cycle pulse after the last stall cycle
cd_err  output  1  sticky: CDen arrived while COUNT was active

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0, sel=0.
  - stall_1, stall_2, cd_busy, cd_done, cd_err all =0.
  - Takes effect immediately, including mid-countdown; resumes in IDLE on the first edge after deassertion.
- States: IDLE, COUNT, DONE.
  - All outputs are registered or decoded from registers only; no input-to-output combinational path.
- Load, accepted in IDLE or DONE:
  - Condition: edge with CDen=1, CDAmt≠0, flush=0.
  - Sets count=min(CDAmt, MAX_AMT), sel=CDsel, state=COUNT.
  - CDAmt=0 is ignored: no state change, no error.
- COUNT:
  - stall_1 = ~sel, stall_2 = sel, cd_busy=1, cd_count=count.
  - Each edge with freeze=0: count−1; if count was 1, go to DONE (count=0).
  - freeze=1: count and state hold.
- Latency: CDen sampled at edge t with N=CDAmt (no freeze) gives stall high for cycles t+1 … t+N, and cd_done high in cycle t+N+1.
- DONE:
  - cd_done=1, stall outputs=0, cd_busy=0, lasts one cycle.
  - Goes to IDLE, or to COUNT if a new load is accepted (back-to-back). cd_done still pulses in that cycle.
- CDen while in COUNT:
  - Ignored; countdown is not retriggered or extended.
  - cd_err set to 1 and held until reset.
  - Applies even when freeze=1.
- flush=1 on any edge:
  - state=IDLE, count=0, stall outputs drop next cycle, no cd_done pulse.
  - flush has priority over CDen and freeze; a simultaneous CDen is dropped without setting cd_err.
- freeze has no effect in IDLE/DONE; a load during freeze is accepted normally.
- Counter never wraps: decrement only occurs when count≥1.

Test Plan:
- Reset, then CDen=1, CDAmt=3, CDsel=1 for one cycle → stall_2=1 for 3 cycles with cd_count 3,2,1; stall_1=0 throughout; cd_done=1 on the 4th cycle; then IDLE.
- CDAmt=2, CDsel=0 load; freeze=1 for 2 cycles after the first stall cycle → stall_1 high for 4 cycles total with cd_count sequence 2,1,1,1; cd_done one cycle later.
- Load CDAmt=5, issue CDen (CDAmt=1) on the 2nd stall cycle → still exactly 5 stall cycles; cd_err=1 from the next cycle until rst.
- Load CDAmt=4, flush on the 2nd stall cycle → stall deasserts the next cycle, cd_busy=0, cd_done never pulses.
- In the DONE cycle, CDen=1, CDAmt=1, CDsel=0 after a pipe-2 countdown → cd_done=1 and the next cycle stall_1=1 for exactly one cycle, stall_2=0.
- Assert rst asynchronously mid-countdown (cd_count=2) → all outputs 0 before the next edge. Separately, CDAmt=0 with CDen=1 → no stall and no cd_err.
